// File: rtl/hazard_ctrl_if.sv
// D-stage decode fields into the hazard controller and its stall/forward results.
interface hazard_ctrl_if;
  logic       d_valid;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic       d_we;
  logic [4:0] d_wdes;
  logic [1:0] d_tnew;
  logic [1:0] d_md;
  logic       stall;
  logic       e_bubble;
  logic [1:0] fwd_rs;
  logic [1:0] fwd_rt;
  logic       md_busy;
  logic [4:0] e_des;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_wdes, d_tnew, d_md,
    input  stall, e_bubble, fwd_rs, fwd_rt, md_busy, e_des
  );
  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_wdes, d_tnew, d_md,
    output stall, e_bubble, fwd_rs, fwd_rt, md_busy, e_des
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew stall and forward controller for the 5-stage MIPS pipeline,
// with E/M write-back shadows and the mult/div busy counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hif
);
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_E   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  logic       e_we_q,   e_we_d;
  logic [4:0] e_des_q,  e_des_d;
  logic [1:0] e_tnew_q, e_tnew_d;
  logic [1:0] e_md_q,   e_md_d;
  logic       m_we_q,   m_we_d;
  logic [4:0] m_des_q,  m_des_d;
  logic [1:0] m_tnew_q, m_tnew_d;
  logic [4:0] cnt_q,    cnt_d;

  logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
  logic data_hz, md_busy, stall;
  logic [1:0] fwd_rs, fwd_rt;

  // $0 is hardwired, so it never produces a match
  function automatic logic hit(input logic we, input logic [4:0] des, input logic [4:0] r);
    return we && (des == r) && (r != 5'd0);
  endfunction

  always_comb begin
    e_hit_rs = hit(e_we_q, e_des_q, hif.d_rs);
    e_hit_rt = hit(e_we_q, e_des_q, hif.d_rt);
    m_hit_rs = hit(m_we_q, m_des_q, hif.d_rs);
    m_hit_rt = hit(m_we_q, m_des_q, hif.d_rt);

    data_hz = (hif.d_tuse_rs != TUSE_NONE &&
               ((e_hit_rs && e_tnew_q > hif.d_tuse_rs) ||
                (m_hit_rs && m_tnew_q > hif.d_tuse_rs))) ||
              (hif.d_tuse_rt != TUSE_NONE &&
               ((e_hit_rt && e_tnew_q > hif.d_tuse_rt) ||
                (m_hit_rt && m_tnew_q > hif.d_tuse_rt)));

    md_busy = (e_md_q == MD_MULT) || (e_md_q == MD_DIV) || (cnt_q != 5'd0);
    stall   = hif.d_valid && (data_hz || (hif.d_md != 2'b00 && md_busy));

    fwd_rs = FWD_RF;
    if (e_hit_rs && e_tnew_q == 2'd0)      fwd_rs = FWD_E;
    else if (m_hit_rs && m_tnew_q == 2'd0) fwd_rs = FWD_M;

    fwd_rt = FWD_RF;
    if (e_hit_rt && e_tnew_q == 2'd0)      fwd_rt = FWD_E;
    else if (m_hit_rt && m_tnew_q == 2'd0) fwd_rt = FWD_M;
  end

  always_comb begin
    e_we_d   = 1'b0;
    e_des_d  = 5'd0;
    e_tnew_d = 2'd0;
    e_md_d   = 2'b00;
    if (hif.d_valid && !stall) begin
      e_we_d   = hif.d_we;
      e_des_d  = hif.d_wdes;
      e_tnew_d = hif.d_tnew;
      e_md_d   = hif.d_md;
    end

    m_we_d   = e_we_q;
    m_des_d  = e_des_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;

    cnt_d = cnt_q;
    if (e_md_q == MD_MULT)     cnt_d = 5'(MULT_CYCLES);
    else if (e_md_q == MD_DIV) cnt_d = 5'(DIV_CYCLES);
    else if (cnt_q != 5'd0)    cnt_d = cnt_q - 5'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_we_q   <= 1'b0;
      e_des_q  <= 5'd0;
      e_tnew_q <= 2'd0;
      e_md_q   <= 2'b00;
      m_we_q   <= 1'b0;
      m_des_q  <= 5'd0;
      m_tnew_q <= 2'd0;
      cnt_q    <= 5'd0;
    end else begin
      e_we_q   <= e_we_d;
      e_des_q  <= e_des_d;
      e_tnew_q <= e_tnew_d;
      e_md_q   <= e_md_d;
      m_we_q   <= m_we_d;
      m_des_q  <= m_des_d;
      m_tnew_q <= m_tnew_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hif.stall    = stall;
  assign hif.e_bubble = stall;
  assign hif.fwd_rs   = fwd_rs;
  assign hif.fwd_rt   = fwd_rt;
  assign hif.md_busy  = md_busy;
  assign hif.e_des    = e_des_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl: a table of single-cycle D inputs with
// expected outputs, plus hand sequences for mult/div busy and async reset.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();
  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .hif(hif));

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [1:0] trs;
    logic [4:0] rt;
    logic [1:0] trt;
    logic       we;
    logic [4:0] wd;
    logic [1:0] tn;
    logic [1:0] md;
    logic       x_st;
    logic [1:0] x_frs;
    logic [1:0] x_frt;
    logic       x_bsy;
    logic [4:0] x_ed;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t vecs[20];

  function automatic vec_t mk(int v, int rs, int trs, int rt, int trt, int we, int wd, int tn,
                              int md, int st, int frs, int frt, int bsy, int ed);
    vec_t r;
    r.v = 1'(v); r.rs = 5'(rs); r.trs = 2'(trs); r.rt = 5'(rt); r.trt = 2'(trt);
    r.we = 1'(we); r.wd = 5'(wd); r.tn = 2'(tn); r.md = 2'(md);
    r.x_st = 1'(st); r.x_frs = 2'(frs); r.x_frt = 2'(frt); r.x_bsy = 1'(bsy); r.x_ed = 5'(ed);
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    hif.d_valid = x.v;    hif.d_rs = x.rs;   hif.d_tuse_rs = x.trs;
    hif.d_rt = x.rt;      hif.d_tuse_rt = x.trt;
    hif.d_we = x.we;      hif.d_wdes = x.wd; hif.d_tnew = x.tn; hif.d_md = x.md;
  endtask

  // inputs change on the falling edge; outputs are sampled 1 time unit later
  task automatic apply(input vec_t x);
    @(negedge clk);
    drive(x);
    #1;
  endtask

  task automatic chk_all(input string nm, input vec_t x);
    chk({nm, ".stall"},    int'(hif.stall),    int'(x.x_st));
    chk({nm, ".e_bubble"}, int'(hif.e_bubble), int'(x.x_st));
    chk({nm, ".fwd_rs"},   int'(hif.fwd_rs),   int'(x.x_frs));
    chk({nm, ".fwd_rt"},   int'(hif.fwd_rt),   int'(x.x_frt));
    chk({nm, ".md_busy"},  int'(hif.md_busy),  int'(x.x_bsy));
    chk({nm, ".e_des"},    int'(hif.e_des),    int'(x.x_ed));
  endtask

  task automatic md_seq(input string nm, input int md, input int exp_cycles);
    vec_t st, mf;
    int n;
    st = mk(1, 0,3, 0,3, 0,0,0, md, 0,0,0,0,0);
    mf = mk(1, 0,3, 0,3, 1,12,1, 3, 0,0,0,0,0);
    apply(st);
    chk({nm, ".start_stall"}, int'(hif.stall), 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      apply(mf);
      if (!hif.stall) break;
      chk({nm, ".busy_while_stall"}, int'(hif.md_busy), 1);
      n++;
    end
    chk({nm, ".stall_cycles"}, n, exp_cycles);
    chk({nm, ".busy_after"}, int'(hif.md_busy), 0);
  endtask

  initial begin
    vec_t nop, addx, mfhi;
    vecs[0]  = mk(0, 0,3, 0,3, 0,0,0, 0,  0,0,0,0,0);
    vecs[1]  = mk(1, 9,1, 8,3, 1,8,2, 0,  0,0,0,0,0);   // lw $8
    vecs[2]  = mk(1, 8,1, 9,1, 1,10,1,0,  1,0,0,0,8);   // add rs=$8: load-use
    vecs[3]  = mk(1, 8,1, 9,1, 1,10,1,0,  0,0,0,0,0);   // M.tnew=1, no stall
    vecs[4]  = mk(1,10,0, 0,0, 0,0,0, 0,  1,0,0,0,10);  // beq after add $10
    vecs[5]  = mk(1,10,0, 0,0, 0,0,0, 0,  0,2,0,0,0);   // forward from M
    vecs[6]  = mk(1, 0,3, 0,3, 1,31,0,0,  0,0,0,0,0);   // jal
    vecs[7]  = mk(1,31,0, 0,3, 0,0,0, 0,  0,1,0,0,31);  // jr $31 from E
    vecs[8]  = mk(1,31,1,31,1, 0,0,0, 0,  0,2,2,0,0);   // $31 from M, both operands
    vecs[9]  = mk(1, 0,1, 0,3, 1,5,1, 0,  0,0,0,0,0);   // ori $5
    vecs[10] = mk(1, 5,1, 0,3, 1,5,1, 0,  0,0,0,0,5);   // E.tnew=1 == tuse
    vecs[11] = mk(1, 5,1, 5,1, 0,0,0, 0,  0,2,2,0,5);   // E match not ready, M ready
    vecs[12] = mk(1, 0,3, 0,3, 1,31,0,0,  0,0,0,0,0);   // jal
    vecs[13] = mk(1, 0,3, 0,3, 1,31,0,0,  0,0,0,0,31);  // jal
    vecs[14] = mk(1,31,0, 5,0, 0,0,0, 0,  0,1,0,0,31);  // E beats M
    vecs[15] = mk(1, 0,3, 0,3, 1,0,2, 0,  0,0,0,0,0);   // lw $0
    vecs[16] = mk(1, 0,1, 0,0, 0,0,0, 0,  0,0,0,0,0);   // $0 never stalls
    vecs[17] = mk(1, 0,3, 0,3, 1,8,2, 0,  0,0,0,0,0);   // lw $8
    vecs[18] = mk(0, 8,0, 8,0, 0,0,0, 3,  0,0,0,0,8);   // invalid D ignored
    vecs[19] = mk(0, 8,0, 0,3, 0,0,0, 0,  0,0,0,0,0);   // E emptied by invalid D

    nop = vecs[0];
    drive(nop);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", nop);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i]);
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end

    md_seq("div", 2, 11);
    md_seq("mult", 1, 6);

    addx = mk(1, 0,3, 0,3, 1,7,1, 0, 0,0,0,0,0);
    mfhi = mk(1, 0,3, 0,3, 1,12,1, 3, 0,0,0,0,0);
    apply(mk(1, 0,3, 0,3, 0,0,0, 2, 0,0,0,0,0));
    repeat (4) apply(addx);
    apply(mfhi);
    chk("rst.pre_stall", int'(hif.stall), 1);
    chk("rst.pre_busy",  int'(hif.md_busy), 1);
    chk("rst.pre_edes",  int'(hif.e_des), 7);
    reset = 1'b0;
    #1;
    chk("rst.stall",    int'(hif.stall), 0);
    chk("rst.e_bubble", int'(hif.e_bubble), 0);
    chk("rst.md_busy",  int'(hif.md_busy), 0);
    chk("rst.e_des",    int'(hif.e_des), 0);
    @(negedge clk);
    reset = 1'b1;
    apply(mk(1, 3,1, 4,1, 1,9,1, 0, 0,0,0,0,0));
    chk("post.stall",   int'(hif.stall), 0);
    chk("post.md_busy", int'(hif.md_busy), 0);
    apply(nop);
    chk("post.e_des",   int'(hif.e_des), 9);
    chk("post.busy2",   int'(hif.md_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
